// File: rtl/sram_like_responder_pkg.sv
// Shared encodings, payload types and helpers for the sram-like responder.
package sram_like_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [31:0]       addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: each entry holds its read data and a saturating age
// counter so the head is released only once it has waited DELAY cycles.
module sram_like_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full_c,
  output logic              head_ready_c,
  output logic [DATA_W-1:0] head_data_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = (DELAY > 1) ? $clog2(DELAY + 1) : 1;

  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(DELAY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [AGE_W-1:0]  age_d  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Every slot ages every cycle; stale slots are harmless since a push restarts their age.
  always_comb begin
    data_d   = data_q;
    age_d    = age_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (age_q[i] < AGE_MAX) age_d[i] = age_q[i] + AGE_W'(1);
    end

    if (push) begin
      data_d[wr_ptr_q] = push_data;
      age_d[wr_ptr_q]  = AGE_W'(1);
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end

    if (pop) rd_ptr_d = next_ptr(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '{default: '0};
      age_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      age_q    <= age_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head_valid_c = (count_q != '0);
    full_c       = (count_q == CNT_FULL);
    head_ready_c = head_valid_c & (age_q[rd_ptr_q] >= AGE_MAX);
    head_data_c  = data_q[rd_ptr_q];
  end

endmodule

// File: rtl/sram_like_responder.sv
// Behavioural sram-like responder: word memory with byte-masked writes and an
// in-order, delayed response queue with stall injection on both channels.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned RESP_DELAY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  input  logic              addr_block,
  input  logic              data_block
);

  localparam int unsigned MEM_WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_we_c;

  sram_req_t         req_c;
  logic [ADDR_W-1:0] idx_c;
  logic              hs_c;
  logic              pop_c;
  logic [DATA_W-1:0] push_data_c;
  logic              fifo_full_c;
  logic              head_ready_c;
  logic [DATA_W-1:0] head_data_c;
  logic              size_legal_c;
  logic              unused_c;

  assign req_c = '{wr: wr, size: size, addr: addr, wstrb: wstrb, wdata: wdata};

  // Request side: no bypass, a full queue refuses even while it is popping.
  always_comb begin
    idx_c        = req_c.addr[ADDR_W+1:2];
    addr_ok      = req & ~reset & ~addr_block & ~fifo_full_c;
    hs_c         = req & addr_ok;
    push_data_c  = req_c.wr ? '0 : mem_q[idx_c];
    mem_we_c     = hs_c & req_c.wr;
    mem_wdata_d  = merge_bytes(mem_q[idx_c], req_c.wdata, req_c.wstrb);
  end

  // Response side: reset drops the queue, so nothing may escape during it.
  always_comb begin
    data_ok = head_ready_c & ~data_block & ~reset;
    pop_c   = data_ok;
    rdata   = data_ok ? head_data_c : '0;
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= mem_wdata_d;
  end

  sram_like_resp_fifo #(
    .DEPTH (OUTSTANDING),
    .DELAY (RESP_DELAY)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (hs_c),
    .push_data    (push_data_c),
    .pop          (pop_c),
    .full_c       (fifo_full_c),
    .head_ready_c (head_ready_c),
    .head_data_c  (head_data_c)
  );

  // size and the ignored address bits are informational only.
  assign size_legal_c = (req_c.size == SIZE_B) | (req_c.size == SIZE_H) | (req_c.size == SIZE_W);
  assign unused_c     = ^{req_c.addr[31:ADDR_W+2], req_c.addr[1:0], size_legal_c};

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed + random checks of two responder instances (delay 1 and delay 3)
// against a timestamp-based queue model.
module tb_sram_like_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_block;
  logic        data_block;
  logic        aok [2];
  logic        dok [2];
  logic [31:0] rd  [2];

  sram_like_responder #(.ADDR_W(12), .OUTSTANDING(2), .RESP_DELAY(1)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]),
    .addr_block(addr_block), .data_block(data_block));

  sram_like_responder #(.ADDR_W(6), .OUTSTANDING(2), .RESP_DELAY(3)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]),
    .addr_block(addr_block), .data_block(data_block));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    longint      rdy;
  } ent_t;

  ent_t        mq [2][$];
  logic [31:0] mem_m [2][4096];
  logic [31:0] init_v [16];
  longint      cyc;
  int          n_assert;
  int          n_fail;
  logic        obs_aok [2];
  logic        obs_dok [2];
  logic [31:0] obs_rd  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare both DUTs at the negedge, then advance the model to the posedge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int          idx;
      longint      dly;
      logic        e_aok;
      logic        e_dok;
      logic [31:0] e_rd;
      ent_t        e;
      idx   = (d == 0) ? int'(addr[13:2]) : int'(addr[7:2]);
      dly   = (d == 0) ? 1 : 3;
      e_aok = req && !reset && !addr_block && (mq[d].size() < 2);
      e_dok = 1'b0;
      e_rd  = 32'h0;
      if (mq[d].size() > 0) begin
        if (!reset && !data_block && (cyc >= mq[d][0].rdy)) begin
          e_dok = 1'b1;
          e_rd  = mq[d][0].val;
        end
      end
      obs_aok[d] = aok[d];
      obs_dok[d] = dok[d];
      obs_rd[d]  = rd[d];
      check($sformatf("addr_ok%0d@%0d", d, cyc), 32'(aok[d]), 32'(e_aok));
      check($sformatf("data_ok%0d@%0d", d, cyc), 32'(dok[d]), 32'(e_dok));
      check($sformatf("rdata%0d@%0d", d, cyc), rd[d], e_rd);
      if (reset) begin
        mq[d].delete();
      end else begin
        if (e_dok) void'(mq[d].pop_front());
        if (e_aok) begin
          e.val = wr ? 32'h0 : mem_m[d][idx];
          e.rdy = cyc + dly;
          mq[d].push_back(e);
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) mem_m[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req   = r;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
    size  = 2'(a[1:0]);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset      = 1'b0;
    addr_block = 1'b0;
    data_block = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic        a2 [8];
    logic        d2 [8];
    logic [31:0] r2 [8];
    logic        any_dok;
    logic [31:0] r;

    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    reset      = 1'b1;
    addr_block = 1'b0;
    data_block = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) tick();
    check("reset_addr_ok", 32'(obs_aok[0]), 32'h0);
    check("reset_rdata", obs_rd[0], 32'h0);

    // Initialise words 0..15, spaced so the delay-3 instance never stalls.
    idle(1);
    for (int i = 0; i < 16; i++) begin
      init_v[i] = $urandom();
      drive(1'b1, 1'b1, 32'(i * 4), 4'hF, init_v[i]);
      tick();
      idle(3);
    end

    // 1: preload idx 0, read through an alias address.
    drive(1'b1, 1'b1, 32'h0, 4'hF, 32'h02c00000);
    tick();
    idle(4);
    drive(1'b1, 1'b0, 32'h1c000000, 4'h0, 32'h0);
    tick();
    check("t1_addr_ok", 32'(obs_aok[0]), 32'h1);
    idle(1);
    check("t1_data_ok", 32'(obs_dok[0]), 32'h1);
    check("t1_rdata", obs_rd[0], 32'h02c00000);
    idle(3);

    // 2: outstanding limit with data_block, released in cycle 5.
    for (int c = 0; c < 8; c++) begin
      data_block = (c < 5);
      drive(c < 7, 1'b0, (c == 0) ? 32'h4 : (c == 1) ? 32'h8 : 32'hC, 4'h0, 32'h0);
      tick();
      a2[c] = obs_aok[0];
      d2[c] = obs_dok[0];
      r2[c] = obs_rd[0];
    end
    check("t2_aok0", 32'(a2[0]), 32'h1);
    check("t2_aok1", 32'(a2[1]), 32'h1);
    check("t2_aok2", 32'(a2[2]), 32'h0);
    check("t2_aok5", 32'(a2[5]), 32'h0);
    check("t2_aok6", 32'(a2[6]), 32'h1);
    check("t2_dok4", 32'(d2[4]), 32'h0);
    check("t2_dok5", 32'(d2[5]), 32'h1);
    check("t2_rd5", r2[5], init_v[1]);
    check("t2_rd6", r2[6], init_v[2]);
    check("t2_rd7", r2[7], init_v[3]);
    idle(4);

    // 3: partial write then read-back.
    drive(1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344);
    tick();
    idle(4);
    drive(1'b1, 1'b1, 32'h10, 4'b0011, 32'hAABBCCDD);
    tick();
    idle(1);
    check("t3_wr_dok", 32'(obs_dok[0]), 32'h1);
    check("t3_wr_rdata", obs_rd[0], 32'h0);
    idle(3);
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    tick();
    idle(1);
    check("t3_rd_rdata", obs_rd[0], 32'h1122CCDD);
    idle(3);

    // 4: delay-3 instance, reads in cycles 0 and 1.
    for (int c = 0; c < 6; c++) begin
      drive(c < 2, 1'b0, (c == 0) ? 32'h14 : 32'h18, 4'h0, 32'h0);
      if (c >= 2) req = 1'b0;
      tick();
      a2[c] = obs_dok[1];
      r2[c] = obs_rd[1];
    end
    check("t4_dok2", 32'(a2[2]), 32'h0);
    check("t4_dok3", 32'(a2[3]), 32'h1);
    check("t4_rd3", r2[3], init_v[5]);
    check("t4_dok4", 32'(a2[4]), 32'h1);
    check("t4_rd4", r2[4], init_v[6]);
    check("t4_dok5", 32'(a2[5]), 32'h0);
    idle(2);

    // 5: reset drops outstanding reads but keeps memory.
    drive(1'b1, 1'b1, 32'h1C, 4'hF, 32'hCAFEF00D);
    tick();
    idle(4);
    data_block = 1'b1;
    drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h24, 4'h0, 32'h0);
    tick();
    req = 1'b0;
    tick();
    reset = 1'b1;
    req   = 1'b1;
    tick();
    check("t5_rst_aok", 32'(obs_aok[0]), 32'h0);
    any_dok = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset      = 1'b0;
    data_block = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      any_dok = any_dok | obs_dok[0] | obs_dok[1];
    end
    check("t5_no_dok", 32'(any_dok), 32'h0);
    drive(1'b1, 1'b0, 32'h1C, 4'h0, 32'h0);
    tick();
    idle(1);
    check("t5_persist0", obs_rd[0], 32'hCAFEF00D);
    idle(2);
    check("t5_persist1", obs_rd[1], 32'hCAFEF00D);
    idle(2);

    // 6: addr_block stalls acceptance, release accepts immediately.
    addr_block = 1'b1;
    drive(1'b1, 1'b0, 32'h28, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t6_blk_aok%0d", c), 32'(obs_aok[0]), 32'h0);
      check($sformatf("t6_blk_dok%0d", c), 32'(obs_dok[0]), 32'h0);
    end
    addr_block = 1'b0;
    tick();
    check("t6_aok", 32'(obs_aok[0]), 32'h1);
    idle(1);
    check("t6_rdata", obs_rd[0], init_v[10]);
    idle(3);

    // Random traffic over the initialised words with aliasing upper/low address bits.
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
            {r[31:14], 8'h00, 4'($urandom_range(0, 15)), r[1:0]},
            4'($urandom()), $urandom());
      size       = 2'($urandom());
      addr_block = ($urandom_range(0, 9) < 2);
      data_block = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
